// File: rtl/sixbit_bist_pkg.sv
// Shared constants, FSM state encoding and golden-result type for the 6-bit adder BIST.
package sixbit_bist_pkg;

    localparam int DATA_W  = 6;
    localparam int VEC_W   = 13;
    localparam int ERR_W   = 14;
    localparam int NUM_VEC = 8192;

    localparam logic [VEC_W-1:0] LAST_VEC = 13'h1FFF;
    localparam logic [ERR_W-1:0] ERR_MAX  = 14'd8192;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIVE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } bist_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              c;
        logic              ov;
    } golden_t;

    // Error counter increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        logic [ERR_W-1:0] res;
        if (cnt >= ERR_MAX) begin
            res = ERR_MAX;
        end else begin
            res = cnt + 14'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sixbit_adder_bist_golden.sv
// Combinational reference 6-bit add/subtract with carry (no-borrow) and signed overflow.
module sixbit_golden_model
    import sixbit_bist_pkg::*;
(
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              sel,
    output logic [DATA_W-1:0] sum,
    output logic              c,
    output logic              ov
);

    logic [DATA_W-1:0] y_eff_s;
    logic [DATA_W:0]   total_s;

    // Subtract is x + ~y + 1, so the inverted operand also feeds the overflow test.
    always_comb begin
        if (sel) begin
            y_eff_s = ~y;
        end else begin
            y_eff_s = y;
        end
        total_s = {1'b0, x} + {1'b0, y_eff_s} + {{DATA_W{1'b0}}, sel};
        sum     = total_s[DATA_W-1:0];
        c       = total_s[DATA_W];
        ov      = (x[DATA_W-1] == y_eff_s[DATA_W-1]) && (total_s[DATA_W-1] != x[DATA_W-1]);
    end

endmodule

// File: rtl/sixbit_adder_bist.sv
// Exhaustive BIST sweep of an external 6-bit adder/subtractor over all 8192 {sel,x,y} vectors.
// Optional first-failure capture outputs are enabled with macro SIXBIT_BIST_FIRST_FAIL_EN.
module sixbit_adder_bist
    import sixbit_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int DATA_W        = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic              sel_out,
    input  logic [DATA_W-1:0] sum_in,
    input  logic              c_in,
    input  logic              overflow_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
    ,
    output logic [VEC_W-1:0]  fail_vec,
    output logic [DATA_W-1:0] fail_sum,
    output logic              fail_c,
    output logic              fail_ov,
    output logic              fail_valid
`endif
);

    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    bist_state_t       state_r;
    bist_state_t       state_s;
    logic [VEC_W-1:0]  vec_r;
    logic [3:0]        wait_cnt_r;
    logic [DATA_W-1:0] gold_sum_s;
    logic              gold_c_s;
    logic              gold_ov_s;
    golden_t           golden_s;
    golden_t           observed_s;
    logic              start_accept_s;
    logic              mismatch_s;
    logic [ERR_W-1:0]  err_next_s;

    sixbit_golden_model u_golden (
        .x   (x_out),
        .y   (y_out),
        .sel (sel_out),
        .sum (gold_sum_s),
        .c   (gold_c_s),
        .ov  (gold_ov_s)
    );

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = DRIVE;
                end else begin
                    state_s = state_r;
                end
            end
            DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    state_s = WAIT;
                end else begin
                    state_s = CHECK;
                end
            end
            WAIT: begin
                if (wait_cnt_r == SETTLE_LAST) begin
                    state_s = CHECK;
                end else begin
                    state_s = WAIT;
                end
            end
            CHECK: begin
                if (vec_r == LAST_VEC) begin
                    state_s = DONE;
                end else begin
                    state_s = DRIVE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Result comparison and the error count that will be visible after this edge.
    always_comb begin
        golden_s       = {gold_sum_s, gold_c_s, gold_ov_s};
        observed_s     = {sum_in, c_in, overflow_in};
        start_accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        mismatch_s     = (state_r == CHECK) && (golden_s != observed_s);
        if (start_accept_s) begin
            err_next_s = 14'd0;
        end else if (mismatch_s) begin
            err_next_s = sat_inc(err_count);
        end else begin
            err_next_s = err_count;
        end
    end

    // Sequencer state, vector index, operand drive and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            vec_r      <= 13'd0;
            wait_cnt_r <= 4'd0;
            x_out      <= 6'd0;
            y_out      <= 6'd0;
            sel_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 14'd0;
        end else begin
            state_r <= state_s;
            if (start_accept_s) begin
                vec_r <= 13'd0;
            end else if ((state_r == CHECK) && (vec_r != LAST_VEC)) begin
                vec_r <= vec_r + 13'd1;
            end else begin
                vec_r <= vec_r;
            end
            if (state_r == WAIT) begin
                wait_cnt_r <= wait_cnt_r + 4'd1;
            end else begin
                wait_cnt_r <= 4'd0;
            end
            if (state_r == DRIVE) begin
                {sel_out, x_out, y_out} <= vec_r;
            end else begin
                {sel_out, x_out, y_out} <= {sel_out, x_out, y_out};
            end
            busy      <= (state_s == DRIVE) || (state_s == WAIT) || (state_s == CHECK);
            done      <= (state_s == DONE);
            pass      <= (state_s == DONE) && (err_next_s == 14'd0);
            err_count <= err_next_s;
        end
    end

`ifdef SIXBIT_BIST_FIRST_FAIL_EN
    // Latch the first mismatching vector and what the adder returned for it.
    always_ff @(posedge clk) begin
        if (rst || start_accept_s) begin
            fail_vec   <= 13'd0;
            fail_sum   <= 6'd0;
            fail_c     <= 1'b0;
            fail_ov    <= 1'b0;
            fail_valid <= 1'b0;
        end else if (mismatch_s && !fail_valid) begin
            fail_vec   <= vec_r;
            fail_sum   <= sum_in;
            fail_c     <= c_in;
            fail_ov    <= overflow_in;
            fail_valid <= 1'b1;
        end else begin
            fail_vec   <= fail_vec;
            fail_sum   <= fail_sum;
            fail_c     <= fail_c;
            fail_ov    <= fail_ov;
            fail_valid <= fail_valid;
        end
    end
`endif

endmodule

// File: tb/tb_sixbit_adder_bist.sv
// Bench for sixbit_adder_bist: golden-model vector table plus full sweeps against a behavioural adder with injectable faults.
module tb_sixbit_adder_bist;

    localparam int SWEEP_CYCLES = 24576;
    localparam int BUDGET       = 30000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  x_out, y_out;
    logic        sel_out;
    logic [5:0]  sum_in;
    logic        c_in, overflow_in;
    logic        busy, done, pass;
    logic [13:0] err_count;
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
    logic [12:0] fail_vec;
    logic [5:0]  fail_sum;
    logic        fail_c, fail_ov, fail_valid;
`endif

    int checks   = 0;
    int failures = 0;
    int mode     = 0;  // 0 correct, 1 sum[0] stuck at 0, 2 overflow tied to 0

    always #5 clk = ~clk;

    sixbit_adder_bist #(.SETTLE_CYCLES(1), .DATA_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .x_out       (x_out),
        .y_out       (y_out),
        .sel_out     (sel_out),
        .sum_in      (sum_in),
        .c_in        (c_in),
        .overflow_in (overflow_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .err_count   (err_count)
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
        ,
        .fail_vec    (fail_vec),
        .fail_sum    (fail_sum),
        .fail_c      (fail_c),
        .fail_ov     (fail_ov),
        .fail_valid  (fail_valid)
`endif
    );

    // Behavioural adder under test, computed with integer arithmetic.
    int ux, uy, sx, sy, sres;
    always_comb begin
        ux = int'(x_out);
        uy = int'(y_out);
        sx = x_out[5] ? ux - 64 : ux;
        sy = y_out[5] ? uy - 64 : uy;
        if (sel_out) begin
            sum_in = 6'(ux - uy);
            c_in   = (ux >= uy);
            sres   = sx - sy;
        end else begin
            sum_in = 6'(ux + uy);
            c_in   = (ux + uy) > 63;
            sres   = sx + sy;
        end
        overflow_in = (sres > 31) || (sres < -32);
        if (mode == 1) sum_in[0] = 1'b0;
        if (mode == 2) overflow_in = 1'b0;
    end

    logic [5:0] gm_x, gm_y, gm_sum;
    logic       gm_sel, gm_c, gm_ov;
    sixbit_golden_model gm (
        .x(gm_x), .y(gm_y), .sel(gm_sel), .sum(gm_sum), .c(gm_c), .ov(gm_ov)
    );

    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic       sel;
        logic [5:0] sum;
        logic       c;
        logic       ov;
    } gvec_t;

    gvec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start-sampling edge until done; optionally pulses start mid-sweep.
    task automatic wait_done(input int pulse_at, output int n);
        n = 0;
        while (!done && n < BUDGET) begin
            start = (n == pulse_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL sweep_timeout actual=%0d required=%0d", n, SWEEP_CYCLES);
        end
    endtask

    int n;
    int k;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        tbl[0] = '{6'd0,  6'd0,  1'b0, 6'd0,       1'b0, 1'b0};
        tbl[1] = '{6'd63, 6'd1,  1'b0, 6'd0,       1'b1, 1'b0};
        tbl[2] = '{6'd31, 6'd1,  1'b0, 6'b100000,  1'b0, 1'b1};
        tbl[3] = '{6'd32, 6'd32, 1'b0, 6'd0,       1'b1, 1'b1};
        tbl[4] = '{6'd63, 6'd63, 1'b0, 6'b111110,  1'b1, 1'b0};
        tbl[5] = '{6'b100000, 6'b000001, 1'b1, 6'b011111, 1'b1, 1'b1};
        tbl[6] = '{6'd0,  6'd1,  1'b1, 6'b111111,  1'b0, 1'b0};
        tbl[7] = '{6'd5,  6'd5,  1'b1, 6'd0,       1'b1, 1'b0};
        tbl[8] = '{6'd31, 6'd63, 1'b1, 6'b100000,  1'b0, 1'b1};
        tbl[9] = '{6'd0,  6'd0,  1'b1, 6'd0,       1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            gm_x = tbl[i].x; gm_y = tbl[i].y; gm_sel = tbl[i].sel;
            #1;
            check($sformatf("golden_vec%0d", i), {24'd0, gm_sum, gm_c, gm_ov},
                  {24'd0, tbl[i].sum, tbl[i].c, tbl[i].ov});
        end

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 14'd0);
        check("rst_ops", {x_out, y_out, sel_out}, 13'd0);
        rst = 1'b0;
        @(negedge clk);

        // Stuck sum[0], with a start pulse while busy that must be ignored.
        mode = 1;
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        wait_done(5000, n);
        check("stuck_cycles", n, SWEEP_CYCLES);
        check("stuck_err", err_count, 14'd4096);
        check("stuck_pass", pass, 1'b0);
        check("stuck_busy", busy, 1'b0);
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
        check("stuck_fail_valid", fail_valid, 1'b1);
        check("stuck_fail_vec", fail_vec, 13'h0001);
        check("stuck_fail_sum", fail_sum, 6'b000000);
`endif

        // Start from DONE clears status, then overflow-tied-low sweep.
        mode = 2;
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_pass", pass, 1'b0);
        check("restart_err", err_count, 14'd0);
        check("restart_busy", busy, 1'b1);
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
        check("restart_fail_valid", fail_valid, 1'b0);
`endif
        wait_done(-1, n);
        check("ov0_cycles", n, SWEEP_CYCLES);
        check("ov0_err", err_count, 14'd2048);
        check("ov0_pass", pass, 1'b0);

        // Reset during WAIT of vector 100 = {0, 6'd1, 6'd36}.
        mode = 1;
        pulse_start();
        k = 0;
        while (!(x_out == 6'd1 && y_out == 6'd36 && sel_out == 1'b0) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("reach_vec100", (k < 1000), 1'b1);
        check("errs_before_rst", (err_count != 14'd0), 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_x", x_out, 6'd0);
        check("midrst_err", err_count, 14'd0);
        check("midrst_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Clean sweep after the aborted one.
        mode = 0;
        pulse_start();
        wait_done(-1, n);
        check("good_cycles", n, SWEEP_CYCLES);
        check("good_err", err_count, 14'd0);
        check("good_pass", pass, 1'b1);
        check("good_done", done, 1'b1);
`ifdef SIXBIT_BIST_FIRST_FAIL_EN
        check("good_fail_valid", fail_valid, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
